// File: rtl/mips_state_dump_pkg.sv
// mips_state_dump_pkg: shared state encoding and dump geometry for the halt/dump block
package mips_state_dump_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
    localparam int NUM_REGS = 32;
    localparam int DUMP_BEATS = NUM_REGS + 1;
    localparam int IDX_PC = 0;
endpackage

// File: rtl/mips_state_dump_halt_detect.sv
// mips_state_dump_halt_detect: end-address, self-loop and cycle-budget halt detection
module mips_state_dump_halt_detect #(
    parameter int PC_W       = 32,
    parameter int IDLE_LIMIT = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            clear,
    input  logic [PC_W-1:0] pc_in,
    input  logic [PC_W-1:0] end_pc,
    output logic            halt,
    output logic            timeout
);
    logic [PC_W-1:0]  pc_prev;
    logic [CNT_W-1:0] same_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             same_pc;
    logic             hit_end;
    logic             hit_idle;
    logic             hit_max;
    assign same_pc  = pc_in == pc_prev;
    assign hit_end  = pc_in == end_pc;
    assign hit_idle = same_pc && same_cnt == CNT_W'(IDLE_LIMIT - 1);
    assign hit_max  = cyc_cnt == CNT_W'(MAX_CYCLES - 1);
    assign halt     = run && (hit_end || hit_idle || hit_max);
    assign timeout  = run && hit_max && !hit_end && !hit_idle;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pc_prev  <= '0;
            same_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (run) begin
            pc_prev  <= pc_in;
            same_cnt <= !same_pc ? CNT_W'(1) : &same_cnt ? same_cnt : same_cnt + 1'b1;
            cyc_cnt  <= &cyc_cnt ? cyc_cnt : cyc_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mips_state_dump.sv
// mips_state_dump: halts the core at program end and streams PC plus $0..$31 over valid/ready
module mips_state_dump
    import mips_state_dump_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int IDLE_LIMIT = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   end_pc,
    input  logic [PC_W-1:0]   pc_in,
    output logic              cpu_stall,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [5:0]        dout_index,
    output logic [DATA_W-1:0] dout_data,
    output logic              done,
    output logic              timeout
);
    state_t          state;
    logic [5:0]      beat;
    logic [PC_W-1:0] pc_cap;
    logic            run;
    logic            arm;
    logic            halt;
    logic            tmo_hit;
    assign run        = state == RUN;
    assign arm        = start && (state == IDLE || state == DONE);
    assign cpu_stall  = (run && halt) || state == DUMP || state == DONE;
    assign dout_valid = state == DUMP;
    assign done       = state == DONE;
    assign dout_index = beat;
    assign rf_raddr   = beat == 6'(IDX_PC) ? 5'd0 : 5'(beat - 6'd1);
    assign dout_data  = !dout_valid ? '0 : beat == 6'(IDX_PC) ? DATA_W'(pc_cap) : rf_rdata;
    mips_state_dump_halt_detect #(
        .PC_W(PC_W), .IDLE_LIMIT(IDLE_LIMIT), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
    ) u_halt (
        .clk(clk), .rst(rst), .run(run), .clear(arm),
        .pc_in(pc_in), .end_pc(end_pc), .halt(halt), .timeout(tmo_hit)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            pc_cap  <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (arm) begin
                    state   <= RUN;
                    beat    <= '0;
                    timeout <= 1'b0;
                end
                RUN: if (halt) begin
                    state   <= DUMP;
                    pc_cap  <= pc_in;
                    beat    <= '0;
                    timeout <= tmo_hit;
                end
                DUMP: if (dout_ready) begin
                    if (beat == 6'(DUMP_BEATS - 1)) state <= DONE;
                    else beat <= beat + 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_state_dump.sv
// tb_mips_state_dump: randomized scoreboard bench against a sequence-level halt/dump model
module tb_mips_state_dump;
    localparam int IDLE_LIMIT = 4;
    localparam int MAX_CYCLES = 100;
    typedef struct {int idx; logic [31:0] data;} beat_t;
    logic        clk = 0, rst = 1, start = 0, dout_ready = 1;
    logic [31:0] end_pc = 0, pc_in = 0;
    logic        cpu_stall, dout_valid, done, timeout;
    logic [4:0]  rf_raddr;
    logic [5:0]  dout_index;
    logic [31:0] dout_data, rf_rdata;
    logic [31:0] rf[32];
    logic [31:0] seq[128];
    beat_t       q[$];
    int          n_cmp = 0, n_fail = 0, hold_at = -1, held = 0;
    bit          rnd_ready = 0, pend = 0;
    logic [5:0]  p_idx;
    logic [31:0] p_data;
    assign rf_rdata = rf[rf_raddr];
    always #5 clk = ~clk;
    mips_state_dump #(.IDLE_LIMIT(IDLE_LIMIT), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .end_pc(end_pc), .pc_in(pc_in),
        .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_index(dout_index),
        .dout_data(dout_data), .done(done), .timeout(timeout)
    );
    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction
    // Halt point from the sequence: first sample at end_pc, the IDLE_LIMIT-th equal sample in a row, or the last budget cycle.
    function automatic void model(output int hk, output bit tmo);
        int run_len = 0;
        hk = 127;
        tmo = 0;
        for (int k = 0; k < 128; k++) begin
            bit a, b;
            run_len = (k > 0 && seq[k] == seq[k-1]) ? run_len + 1 : 1;
            a = seq[k] == end_pc;
            b = run_len == IDLE_LIMIT;
            if (a || b || k == MAX_CYCLES - 1) begin
                hk = k;
                tmo = !a && !b;
                return;
            end
        end
    endfunction
    always @(posedge clk) begin
        #1;
        if (!dout_valid) held = 0;
        if (dout_valid && int'(dout_index) == hold_at && held < 3) begin
            dout_ready = 0;
            held++;
        end else dout_ready = rnd_ready ? ($urandom_range(2) != 0) : 1'b1;
    end
    always @(negedge clk) begin
        beat_t e;
        if (dout_valid && !rst) begin
            if (pend) begin
                check("hold_index", 32'(dout_index), 32'(p_idx));
                check("hold_data", dout_data, p_data);
            end
            pend = !dout_ready;
            p_idx = dout_index;
            p_data = dout_data;
            if (dout_ready) begin
                check("beat_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("beat_index", 32'(dout_index), e.idx);
                    check("beat_data", dout_data, e.data);
                    check("rf_raddr", 32'(rf_raddr), e.idx == 0 ? 0 : e.idx - 1);
                end
            end
        end else pend = 0;
    end
    task automatic run_prog(input logic [31:0] endp, input int hold, input bit rnd, input int rst_at);
        int hk, cyc;
        bit tmo, got;
        for (int i = 0; i < 32; i++) rf[i] = i == 0 ? 32'd0 : $urandom;
        end_pc = endp;
        hold_at = hold;
        rnd_ready = rnd;
        model(hk, tmo);
        for (int b = 0; b < 33; b++) q.push_back('{b, b == 0 ? seq[hk] : rf[b > 0 ? b - 1 : 0]});
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int k = 0; k <= hk; k++) begin
            pc_in = seq[k];
            @(negedge clk);
            if (k == 0) begin
                check("done_cleared", 32'(done), 0);
                check("timeout_cleared", 32'(timeout), 0);
            end
            check("cpu_stall", 32'(cpu_stall), 32'(k == hk));
            if (k < hk) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        check("valid_after_halt", 32'(dout_valid), 1);
        cyc = 1;
        got = 0;
        while (cyc < 400 && !got) begin
            if (dout_valid && dout_ready && int'(dout_index) == rst_at) begin
                @(posedge clk); #1 rst = 1;
                @(posedge clk); #1 rst = 0;
                @(negedge clk);
                check("rst_valid", 32'(dout_valid), 0);
                check("rst_stall", 32'(cpu_stall), 0);
                check("rst_done", 32'(done), 0);
                q.delete();
                return;
            end
            if (dout_valid && dout_ready && dout_index == 6'd32) got = 1;
            else begin @(negedge clk); cyc++; end
        end
        check("last_beat_seen", 32'(got), 1);
        if (!rnd && hold < 0) check("dump_cycles", cyc, 33);
        @(negedge clk);
        check("done", 32'(done), 1);
        check("valid_off", 32'(dout_valid), 0);
        check("timeout", 32'(timeout), 32'(tmo));
        check("queue_empty", q.size(), 0);
        q.delete();
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_index", 32'(dout_index), 0);
        check("rst_data", dout_data, 0);
        check("rst_raddr", 32'(rf_raddr), 0);
        for (int k = 0; k < 128; k++) seq[k] = 32'(4 * k);
        run_prog(32'h20, -1, 0, -1);
        run_prog(32'h20, 5, 0, -1);
        for (int k = 0; k < 128; k++) seq[k] = k < 7 ? 32'(4 * k) : 32'h1C;
        run_prog(32'h100, -1, 0, -1);
        for (int k = 0; k < 128; k++) seq[k] = 32'(32'h400 + 4 * k);
        run_prog(32'h10, -1, 0, -1);
        for (int k = 0; k < 128; k++) seq[k] = 32'(4 * k);
        run_prog(32'h20, -1, 0, 10);
        run_prog(32'h20, -1, 0, -1);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 128; k++)
                seq[k] = (k > 0 && $urandom_range(2) == 0) ? seq[k > 0 ? k - 1 : 0] : 32'(4 * $urandom_range(15));
            run_prog(32'(4 * $urandom_range(23)), -1, 1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
